// File: rtl/m_cycle_sequencer_pkg.sv
// Shared types for the M-cycle sequencer and its lookup-table interface.
package m_cycle_sequencer_pkg;

  localparam int unsigned OP_W    = 8;
  localparam int unsigned M_LEFT_W = 3;

  typedef enum logic [3:0] {
    M_NOP        = 4'd0,
    M_ROM_READ   = 4'd1,
    M_MEM_READ   = 4'd2,
    M_MEM_WRITE  = 4'd3,
    M_REG_COPY   = 4'd4,
    M_ALU        = 4'd5,
    M_SHIFT      = 4'd6,
    M_PUSH_PCH   = 4'd7,
    M_PUSH_PCL   = 4'd8,
    M_PC_WRITE   = 4'd9,
    M_IME_CHANGE = 4'd10,
    M_HALT       = 4'd11,
    M_STOP       = 4'd12
  } m_cycle_type;

  typedef enum logic [2:0] {
    MODE_MAIN   = 3'd0,
    MODE_PREFIX = 3'd1,
    MODE_INT    = 3'd2,
    MODE_HALT   = 3'd3,
    MODE_STOP   = 3'd4
  } seq_mode_t;

endpackage

// File: rtl/m_cycle_sequencer_if.sv
// Lookup-table bus: sequencer drives opcode/position, table returns M-cycle types.
interface m_cycle_sequencer_if;
  import m_cycle_sequencer_pkg::*;

  logic [OP_W-1:0]     op;
  logic [OP_W-1:0]     op_prefix;
  logic [M_LEFT_W-1:0] m_left;
  m_cycle_type         next_m_cycle;
  m_cycle_type         next_m_cycle_prefix;
  m_cycle_type         next_m_cycle_int;

  modport master (
    output op, op_prefix, m_left,
    input  next_m_cycle, next_m_cycle_prefix, next_m_cycle_int
  );

  modport slave (
    input  op, op_prefix, m_left,
    output next_m_cycle, next_m_cycle_prefix, next_m_cycle_int
  );
endinterface

// File: rtl/m_cycle_sequencer.sv
// Instruction-level sequencer: opcode/CB latch, M-cycle down-counter,
// interrupt dispatch, HALT and STOP.
module m_cycle_sequencer
  import m_cycle_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m_tick,
  input  logic [OP_W-1:0]      fetch_data,
  input  logic [M_LEFT_W-1:0]  m_len,
  input  logic [M_LEFT_W-1:0]  m_len_prefix,
  input  logic                 int_pending,
  input  logic                 ime,
  input  logic                 cond_abort,
  input  logic                 stop_exit,
  m_cycle_sequencer_if.master  lut,
  output m_cycle_type          m_cycle,
  output logic                 fetch,
  output logic                 int_entry,
  output logic                 halted,
  output logic                 stopped
);

  localparam logic [OP_W-1:0]     OP_NOP        = OP_W'(8'h00);
  localparam logic [OP_W-1:0]     OP_STOP       = OP_W'(8'h10);
  localparam logic [OP_W-1:0]     OP_HALT       = OP_W'(8'h76);
  localparam logic [OP_W-1:0]     OP_CB         = OP_W'(8'hCB);
  localparam logic [M_LEFT_W-1:0] M_LEFT_PREFIX = M_LEFT_W'(7);
  localparam logic [M_LEFT_W-1:0] M_LEFT_INT    = M_LEFT_W'(4);

  seq_mode_t           mode_q;
  logic [OP_W-1:0]     op_q;
  logic [OP_W-1:0]     op_prefix_q;
  logic [M_LEFT_W-1:0] m_left_q;
  logic                abort_q;

  assign lut.op        = op_q;
  assign lut.op_prefix = op_prefix_q;
  assign lut.m_left    = m_left_q;

  // Current M-cycle action and fetch overlap, zero latency from registered state
  always_comb begin
    m_cycle = M_NOP;
    fetch   = 1'b0;
    if (abort_q) begin
      fetch = 1'b1;
    end else begin
      case (mode_q)
        MODE_MAIN: begin
          m_cycle = lut.next_m_cycle;
          fetch   = (m_left_q == '0);
        end
        MODE_PREFIX: begin
          m_cycle = lut.next_m_cycle_prefix;
          fetch   = (m_left_q == '0);
        end
        MODE_INT: begin
          m_cycle = lut.next_m_cycle_int;
          fetch   = (m_left_q == '0);
        end
        default: begin
          m_cycle = M_NOP;
          fetch   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q      <= MODE_MAIN;
      op_q        <= OP_NOP;
      op_prefix_q <= OP_NOP;
      m_left_q    <= '0;
      abort_q     <= 1'b0;
      int_entry   <= 1'b0;
      halted      <= 1'b0;
      stopped     <= 1'b0;
    end else if (m_tick) begin
      abort_q   <= 1'b0;
      int_entry <= 1'b0;
      case (mode_q)
        MODE_HALT: begin
          m_left_q <= '0;
          if (int_pending && ime) begin
            mode_q    <= MODE_INT;
            m_left_q  <= M_LEFT_INT;
            int_entry <= 1'b1;
            halted    <= 1'b0;
          end else if (int_pending) begin
            // Wake without dispatch: a single NOP cycle that refetches
            mode_q <= MODE_MAIN;
            op_q   <= OP_NOP;
            halted <= 1'b0;
          end
        end
        MODE_STOP: begin
          m_left_q <= '0;
          if (stop_exit) begin
            mode_q  <= MODE_MAIN;
            op_q    <= OP_NOP;
            stopped <= 1'b0;
          end
        end
        default: begin
          if (fetch) begin
            // Instruction boundary: interrupt beats HALT/STOP entry and the new opcode
            if (int_pending && ime) begin
              mode_q    <= MODE_INT;
              m_left_q  <= M_LEFT_INT;
              int_entry <= 1'b1;
            end else if (mode_q == MODE_MAIN && op_q == OP_HALT && !abort_q) begin
              mode_q <= MODE_HALT;
              halted <= 1'b1;
            end else if (mode_q == MODE_MAIN && op_q == OP_STOP && !abort_q) begin
              mode_q  <= MODE_STOP;
              stopped <= 1'b1;
            end else begin
              op_q     <= fetch_data;
              m_left_q <= m_len;
              mode_q   <= MODE_MAIN;
            end
          end else if (mode_q == MODE_MAIN && op_q == OP_CB && m_left_q == M_LEFT_PREFIX) begin
            op_prefix_q <= fetch_data;
            m_left_q    <= m_len_prefix;
            mode_q      <= MODE_PREFIX;
          end else if (cond_abort && mode_q == MODE_MAIN) begin
            m_left_q <= '0;
            abort_q  <= 1'b1;
          end else begin
            m_left_q <= m_left_q - M_LEFT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_cycle_sequencer.sv
// Directed bench for m_cycle_sequencer with a small stand-in M-cycle lookup table.
module tb_m_cycle_sequencer;
  import m_cycle_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_tick;
  logic [7:0]  fetch_data;
  logic [2:0]  m_len;
  logic [2:0]  m_len_prefix;
  logic        int_pending;
  logic        ime;
  logic        cond_abort;
  logic        stop_exit;
  m_cycle_type m_cycle;
  logic        fetch;
  logic        int_entry;
  logic        halted;
  logic        stopped;

  int total = 0;
  int bad   = 0;

  m_cycle_sequencer_if lut();

  m_cycle_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .m_tick       (m_tick),
    .fetch_data   (fetch_data),
    .m_len        (m_len),
    .m_len_prefix (m_len_prefix),
    .int_pending  (int_pending),
    .ime          (ime),
    .cond_abort   (cond_abort),
    .stop_exit    (stop_exit),
    .lut          (lut),
    .m_cycle      (m_cycle),
    .fetch        (fetch),
    .int_entry    (int_entry),
    .halted       (halted),
    .stopped      (stopped)
  );

  always #5 clk = ~clk;

  // Stand-in lookup table for the opcodes used below
  always_comb begin
    lut.next_m_cycle        = M_NOP;
    lut.next_m_cycle_prefix = M_NOP;
    lut.next_m_cycle_int    = M_NOP;
    case (lut.op)
      8'h41: lut.next_m_cycle = M_REG_COPY;
      8'hCD: case (lut.m_left)
               3'd5, 3'd4: lut.next_m_cycle = M_ROM_READ;
               3'd2:       lut.next_m_cycle = M_PUSH_PCH;
               3'd1:       lut.next_m_cycle = M_PUSH_PCL;
               3'd0:       lut.next_m_cycle = M_PC_WRITE;
               default:    lut.next_m_cycle = M_NOP;
             endcase
      8'hCB: if (lut.m_left == 3'd7) lut.next_m_cycle = M_ROM_READ;
      8'h20: case (lut.m_left)
               3'd2:    lut.next_m_cycle = M_ROM_READ;
               3'd1:    lut.next_m_cycle = M_ALU;
               3'd0:    lut.next_m_cycle = M_PC_WRITE;
               default: lut.next_m_cycle = M_NOP;
             endcase
      8'h76: lut.next_m_cycle = M_HALT;
      8'h10: lut.next_m_cycle = M_STOP;
      default: lut.next_m_cycle = M_NOP;
    endcase
    if (lut.op_prefix == 8'h06) begin
      case (lut.m_left)
        3'd2:    lut.next_m_cycle_prefix = M_MEM_READ;
        3'd1:    lut.next_m_cycle_prefix = M_SHIFT;
        default: lut.next_m_cycle_prefix = M_NOP;
      endcase
    end
    case (lut.m_left)
      3'd4:    lut.next_m_cycle_int = M_IME_CHANGE;
      3'd3:    lut.next_m_cycle_int = M_PUSH_PCH;
      3'd2:    lut.next_m_cycle_int = M_PUSH_PCL;
      3'd1:    lut.next_m_cycle_int = M_PC_WRITE;
      default: lut.next_m_cycle_int = M_NOP;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One M-cycle tick followed by an idle clock, then sample at a negedge
  task automatic tick();
    @(negedge clk);
    m_tick = 1'b1;
    @(negedge clk);
    m_tick = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  m_cycle_type call_seq [6] = '{M_ROM_READ, M_ROM_READ, M_NOP, M_PUSH_PCH, M_PUSH_PCL, M_PC_WRITE};
  m_cycle_type int_seq  [5] = '{M_IME_CHANGE, M_PUSH_PCH, M_PUSH_PCL, M_PC_WRITE, M_NOP};

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; m_tick = 1'b1; fetch_data = 8'hFF; m_len = 3'd0; m_len_prefix = 3'd0;
    int_pending = 1'b0; ime = 1'b0; cond_abort = 1'b0; stop_exit = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0; m_tick = 1'b0;
    @(negedge clk);

    chk("rst_op", 32'(lut.op), 32'h00);
    chk("rst_op_prefix", 32'(lut.op_prefix), 32'h00);
    chk("rst_m_left", 32'(lut.m_left), 32'd0);
    chk("rst_m_cycle", 32'(m_cycle), 32'(M_NOP));
    chk("rst_fetch", 32'(fetch), 32'd1);
    chk("rst_flags", {29'd0, int_entry, halted, stopped}, 32'd0);

    // LD B,C single-cycle
    fetch_data = 8'h41; m_len = 3'd0; tick();
    chk("ld_op", 32'(lut.op), 32'h41);
    chk("ld_m_left", 32'(lut.m_left), 32'd0);
    chk("ld_m_cycle", 32'(m_cycle), 32'(M_REG_COPY));
    chk("ld_fetch", 32'(fetch), 32'd1);

    // CALL nn
    fetch_data = 8'hCD; m_len = 3'd5; tick();
    fetch_data = 8'h00; m_len = 3'd0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("call_m_left%0d", i), 32'(lut.m_left), 32'(5 - i));
      chk($sformatf("call_m_cycle%0d", i), 32'(m_cycle), 32'(call_seq[i]));
      chk($sformatf("call_fetch%0d", i), 32'(fetch), (i == 5) ? 32'd1 : 32'd0);
      if (i < 5) tick();
    end

    // CB 06 (RLC (HL))
    fetch_data = 8'hCB; m_len = 3'd7; tick();
    chk("cb_m_left7", 32'(lut.m_left), 32'd7);
    chk("cb_m_cycle7", 32'(m_cycle), 32'(M_ROM_READ));
    chk("cb_fetch7", 32'(fetch), 32'd0);
    fetch_data = 8'h06; m_len_prefix = 3'd2; m_len = 3'd0; tick();
    chk("cb_op_prefix", 32'(lut.op_prefix), 32'h06);
    chk("cb_m_left2", 32'(lut.m_left), 32'd2);
    chk("cb_m_cycle2", 32'(m_cycle), 32'(M_MEM_READ));
    fetch_data = 8'h00; tick();
    chk("cb_m_left1", 32'(lut.m_left), 32'd1);
    chk("cb_m_cycle1", 32'(m_cycle), 32'(M_SHIFT));
    tick();
    chk("cb_m_left0", 32'(lut.m_left), 32'd0);
    chk("cb_m_cycle0", 32'(m_cycle), 32'(M_NOP));
    chk("cb_fetch0", 32'(fetch), 32'd1);

    // JR NZ with condition false on the offset read
    fetch_data = 8'h20; m_len = 3'd2; tick();
    chk("jr_m_cycle2", 32'(m_cycle), 32'(M_ROM_READ));
    chk("jr_fetch2", 32'(fetch), 32'd0);
    cond_abort = 1'b1; fetch_data = 8'h00; m_len = 3'd0; tick();
    cond_abort = 1'b0;
    chk("jr_abort_m_cycle", 32'(m_cycle), 32'(M_NOP));
    chk("jr_abort_fetch", 32'(fetch), 32'd1);
    chk("jr_abort_m_left", 32'(lut.m_left), 32'd0);
    fetch_data = 8'h41; tick();
    chk("jr_next_op", 32'(lut.op), 32'h41);
    chk("jr_next_m_cycle", 32'(m_cycle), 32'(M_REG_COPY));

    // HALT, woken with IME clear
    fetch_data = 8'h76; tick();
    chk("halt0_m_cycle", 32'(m_cycle), 32'(M_HALT));
    fetch_data = 8'h41; tick();
    chk("halt0_halted", 32'(halted), 32'd1);
    chk("halt0_fetch", 32'(fetch), 32'd0);
    chk("halt0_nop", 32'(m_cycle), 32'(M_NOP));
    tick();
    chk("halt0_hold", 32'(halted), 32'd1);
    int_pending = 1'b1; ime = 1'b0; tick();
    int_pending = 1'b0;
    chk("halt0_wake_halted", 32'(halted), 32'd0);
    chk("halt0_wake_op", 32'(lut.op), 32'h00);
    chk("halt0_wake_fetch", 32'(fetch), 32'd1);
    chk("halt0_wake_int_entry", 32'(int_entry), 32'd0);
    fetch_data = 8'h41; tick();
    chk("halt0_next_op", 32'(lut.op), 32'h41);

    // HALT, woken with IME set -> dispatch
    fetch_data = 8'h76; tick();
    tick();
    chk("halt1_halted", 32'(halted), 32'd1);
    int_pending = 1'b1; ime = 1'b1; tick();
    int_pending = 1'b0; ime = 1'b0;
    chk("halt1_halted_clr", 32'(halted), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("int_m_left%0d", i), 32'(lut.m_left), 32'(4 - i));
      chk($sformatf("int_m_cycle%0d", i), 32'(m_cycle), 32'(int_seq[i]));
      chk($sformatf("int_entry%0d", i), 32'(int_entry), (i == 0) ? 32'd1 : 32'd0);
      chk($sformatf("int_fetch%0d", i), 32'(fetch), (i == 4) ? 32'd1 : 32'd0);
      if (i < 4) tick();
    end
    fetch_data = 8'h41; tick();
    chk("int_next_op", 32'(lut.op), 32'h41);

    // STOP until wake event
    fetch_data = 8'h10; tick();
    chk("stop_m_cycle", 32'(m_cycle), 32'(M_STOP));
    fetch_data = 8'h41; tick();
    chk("stop_stopped", 32'(stopped), 32'd1);
    chk("stop_fetch", 32'(fetch), 32'd0);
    tick();
    chk("stop_hold", 32'(stopped), 32'd1);
    stop_exit = 1'b1; tick();
    stop_exit = 1'b0;
    chk("stop_exit_stopped", 32'(stopped), 32'd0);
    chk("stop_exit_op", 32'(lut.op), 32'h00);
    chk("stop_exit_fetch", 32'(fetch), 32'd1);
    fetch_data = 8'h41; tick();
    chk("stop_next_op", 32'(lut.op), 32'h41);

    // Interrupt at the end of LD B,C, then reset mid-dispatch
    int_pending = 1'b1; ime = 1'b1; fetch_data = 8'h55; m_len = 3'd3; tick();
    int_pending = 1'b0; ime = 1'b0;
    chk("irq_op_kept", 32'(lut.op), 32'h41);
    chk("irq_m_left", 32'(lut.m_left), 32'd4);
    chk("irq_int_entry", 32'(int_entry), 32'd1);
    tick();
    chk("irq_int_entry_clr", 32'(int_entry), 32'd0);
    tick();
    chk("irq_m_left2", 32'(lut.m_left), 32'd2);
    @(negedge clk);
    reset = 1'b1; m_tick = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("irq_rst_m_left", 32'(lut.m_left), 32'd0);
    chk("irq_rst_int_entry", 32'(int_entry), 32'd0);
    chk("irq_rst_op", 32'(lut.op), 32'h00);
    chk("irq_rst_m_cycle", 32'(m_cycle), 32'(M_NOP));
    chk("irq_rst_fetch", 32'(fetch), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/m_cycle_sequencer.md
# m_cycle_sequencer

Instruction-level sequencer of the CPU controller. Latches the opcode and CB-prefix byte, runs the per-instruction M-cycle down-counter `m_left`, and handles interrupt dispatch, HALT and STOP. Drives `op`/`op_prefix`/`m_left` into the M-cycle lookup table, then selects that table's main, prefix or interrupt result as the current M-cycle type for the datapath.

## Interface
- No parameters.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `m_tick` in 1: one-`clk` pulse per M-cycle; all state advances only on `clk` edges with `m_tick`=1.
- `fetch_data` in 8: byte on the bus during the current M-cycle.
- `m_len` in 3: total M-cycles − 1 of the opcode on `fetch_data`, from the companion decode; 7 for 0xCB.
- `m_len_prefix` in 3: total post-prefix M-cycles − 1 of the CB-suffix on `fetch_data`.
- `int_pending` in 1: IF & IE ≠ 0.
- `ime` in 1: interrupt master enable.
- `cond_abort` in 1: condition false this M-cycle; end the instruction.
- `stop_exit` in 1: STOP wake event.
- `next_m_cycle`, `next_m_cycle_prefix`, `next_m_cycle_int` in m_cycle_type: lookup table results.
- `op` out 8: latched opcode.
- `op_prefix` out 8: latched CB suffix.
- `m_left` out 3: remaining M-cycles.
- `m_cycle` out m_cycle_type: current M-cycle action.
- `fetch` out 1: this M-cycle fetches the next opcode; PC increments.
- `int_entry` out 1: one M-cycle pulse, first cycle of dispatch.
- `halted` out 1: in HALT.
- `stopped` out 1: in STOP.

## Operation
- Modes: MAIN, PREFIX, INT, HALT, STOP; plus `abort` flag.
- Mode-to-`m_cycle` mapping:
  - MAIN: `next_m_cycle`.
  - PREFIX: `next_m_cycle_prefix`.
  - INT: `next_m_cycle_int`.
  - HALT, STOP, or `abort`=1: M_NOP.
- The last execute cycle overlaps the next fetch. `fetch`=1 iff `m_left`=0 in MAIN, PREFIX or INT, or `abort`=1. `fetch`=0 in HALT and STOP.
- On a tick in a fetch cycle (instruction end), in priority order:
  1. `int_pending`&`ime`: mode←INT, `m_left`←4, `fetch_data` discarded; `int_entry` high during the following M-cycle.
  2. MAIN, `op`=0x76, not `abort`: mode←HALT.
  3. MAIN, `op`=0x10, not `abort`: mode←STOP.
  4. Otherwise: `op`←`fetch_data`, `m_left`←`m_len`, mode←MAIN.
- Priority 1 applies whenever a fetch cycle ends, including the end of an `abort` cycle and the M_HALT/M_STOP completion cycle. In the latter case mode←INT, not HALT or STOP.
- On a tick in MAIN with `op`=0xCB and `m_left`=7 (the prefix ROM_READ): `op_prefix`←`fetch_data`, `m_left`←`m_len_prefix`, mode←PREFIX.
- On a tick otherwise with `m_left`>0: `m_left`−1.
- `cond_abort` with `m_left`>0 in MAIN: `m_left`←0 and `abort`←1 for exactly one M-cycle. The deferred PC_WRITE never issues. `abort` clears at the end of that cycle. `cond_abort` is ignored when `m_left`=0 or outside MAIN.
- HALT: hold `m_left`=0.
  - `int_pending` with `ime`=1: mode←INT, `m_left`←4.
  - `int_pending` with `ime`=0: mode←MAIN, `op`←0x00, `m_left`←0, i.e. one refetch NOP cycle.
  - HALT bug not modelled.
- STOP: hold until `stop_exit`, then mode←MAIN, `op`←0x00, `m_left`←0.
- `ime` and `int_pending` are sampled only at ticks; EI delay lives in the IME logic.

## Timing
- Reset values:
  - mode=MAIN, `op`=0x00, `op_prefix`=0x00, `m_left`=0, `abort`=0.
  - Therefore `m_cycle`=M_NOP and `fetch`=1 in the first cycle after reset.
  - `int_entry`=0, `halted`=0, `stopped`=0.
- `reset` overrides `m_tick` and every other input. Reset mid-instruction discards all state.
- Register updates occur only on `clk` edges with `m_tick`=1. Between ticks, all outputs are stable.
- `m_cycle` and `fetch` are combinational from registered state plus the table inputs, with zero latency from `op`/`m_left`.
- `int_entry`, `halted` and `stopped` are registered, decoded from mode.
- Instruction length is `m_len`+1 M-cycles. For CB instructions it is 2+`m_len_prefix` M-cycles.
- Interrupt dispatch is 5 M-cycles.

## Test plan
- Reset, then `fetch_data`=0x41, `m_len`=0 → tick 1: `op`=0x41, `m_left`=0, `m_cycle`=M_REG_COPY, `fetch`=1.
- CALL 0xCD, `m_len`=5 → `m_left` sequence 5,4,3,2,1,0; `m_cycle` sequence ROM_READ, ROM_READ, NOP, PUSH_PCH, PUSH_PCL, PC_WRITE; `fetch`=1 only in the last cycle.
- 0xCB then suffix 0x06, `m_len_prefix`=2 → `m_left` 7,2,1,0; `m_cycle` ROM_READ, MEM_READ, SHIFT, NOP; `op_prefix`=0x06.
- JR NZ 0x20, `m_len`=2, `cond_abort` at `m_left`=2 → next cycle M_NOP with `fetch`=1; PC_WRITE never appears; total 2 M-cycles.
- HALT 0x76 with `ime`=0: `halted`=1 → `int_pending` pulse → one cycle with `op`=0x00 and `fetch`=1, then normal fetch. Repeat with `ime`=1 → `int_entry`, `m_cycle` IME_CHANGE, PUSH_PCH, PUSH_PCL, PC_WRITE, NOP.
- `int_pending`&`ime` at the end of a 0x41 fetch → `op` unchanged, `m_left`=4; assert `reset` at `m_left`=2 → mode MAIN, `m_left`=0, `int_entry`=0.
